// File: rtl/avr_spi_pkg.sv
// rtl/avr_spi_pkg.sv - shared types and widths for the AVR SPI register port
package avr_spi_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser for a bus of async lines
// Rise/fall pulses are produced for din[0] only; the other bits are plain synchronised copies.
module spi_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic         prev;

  // Reset to 0 so a chip select already low at reset release does not look like an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync[0];
    end
  end

  assign dout = sync;
  assign rise = sync[0] & ~prev;
  assign fall = ~sync[0] & prev;

endmodule

// File: rtl/avr_spi_regs.sv
// rtl/avr_spi_regs.sv - AVR SPI slave decoding read/write register commands
// Byte 1 is the command (bit 7 = write, 6:0 = address); following bytes are data.
module avr_spi_regs
  import avr_spi_pkg::*;
#(
  parameter int   AUTOINC   = 1,
  parameter logic IDLE_MISO = 1'b1
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              spics_n,
  input  logic              spick,
  input  logic              spido,
  output logic              spidi,
  input  logic [DATA_W-1:0] status,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_stb,
  output logic              busy
);

  logic              cs_n_s;
  logic              mosi_s;
  logic              sck_s;
  logic              sck_rise;
  logic              sck_fall;
  state_t            state;
  state_t            state_next;
  logic              armed;
  logic [2:0]        bitcnt;
  logic [DATA_W-2:0] rx;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx;
  logic [ADDR_W-1:0] addr;
  logic              byte_done;
  logic              last_bit;

  spi_sync_edge #(.W(3)) u_sync (
    .clk  (fclk),
    .rst  (rst),
    .din  ({spido, spics_n, spick}),
    .dout ({mosi_s, cs_n_s, sck_s}),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  assign rx_shift = {rx, mosi_s};
  assign last_bit = sck_rise && (bitcnt == 3'd7);

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!cs_n_s && armed) state_next = CMD;
      CMD: begin
        if (cs_n_s)        state_next = IDLE;
        else if (last_bit) state_next = rx_shift[CMD_WR_BIT] ? WDATA : RDATA;
      end
      WDATA,
      RDATA:   if (cs_n_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      bitcnt    <= '0;
      rx        <= '0;
      tx        <= '0;
      addr      <= '0;
      byte_done <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_stb    <= 1'b0;
      rd_addr   <= '0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (cs_n_s) armed <= 1'b1;
      // A deasserted CS overrides any edge seen in the same cycle, so partial bytes never strobe.
      if (state == IDLE || cs_n_s) begin
        bitcnt    <= '0;
        byte_done <= 1'b0;
        if (state == IDLE) tx <= status;
      end else begin
        if (sck_rise) begin
          rx        <= rx_shift[DATA_W-2:0];
          bitcnt    <= bitcnt + 3'd1;
          byte_done <= (bitcnt == 3'd7);
          if (bitcnt == 3'd7) begin
            if (state == CMD) begin
              addr <= rx_shift[ADDR_W-1:0];
            end else if (state == WDATA) begin
              wr_addr <= addr;
              wr_data <= rx_shift;
              wr_stb  <= 1'b1;
              if (AUTOINC != 0) addr <= addr + 7'd1;
            end
          end
        end else if (sck_fall) begin
          byte_done <= 1'b0;
          if (!byte_done) begin
            tx <= {tx[DATA_W-2:0], 1'b0};
          end else if (state == RDATA) begin
            tx     <= rd_data;
            rd_stb <= 1'b1;
            if (AUTOINC != 0) addr <= addr + 7'd1;
          end else begin
            tx <= '0;
          end
        end
        if (state == RDATA) rd_addr <= addr;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign spidi = busy ? tx[DATA_W-1] : IDLE_MISO;

endmodule

// File: doc/avr_spi_regs.md
Name: avr_spi_regs

Overview:
- FPGA-side SPI slave for the AVR link (spics_n/spick/spido/spidi), replacing the raw pass-through to the SD card with a register-access port.
- Oversamples the SPI lines in the fclk domain and decodes a one-byte command (read or write, plus a 7-bit address).
- Produces write strobes and read fetches toward a downstream register file or FIFO.
- Streams read data back to the AVR on spidi.

Parameters:
- AUTOINC, 1, 1 = address increments after each data byte; 0 = address holds.
- IDLE_MISO, 1'b1, level driven on spidi while spics_n is high.

Ports:
- fclk  in  1  system clock; all logic is single-clock on fclk.
- rst  in  1  asynchronous, active-high reset.
- spics_n  in  1  AVR chip select, asynchronous, active low.
- spick  in  1  AVR SPI clock, asynchronous, mode 0, MSB first.
- spido  in  1  AVR MOSI.
- spidi  out  1  AVR MISO.
- status  in  8  byte returned during the command byte.
- wr_stb  out  1  one-fclk pulse: wr_addr/wr_data valid.
- wr_addr  out  7  write address.
- wr_data  out  8  write data.
- rd_addr  out  7  read address for the downstream mux.
- rd_data  in  8  data at rd_addr; must be valid 1 fclk after rd_addr changes.
- rd_stb  out  1  one-fclk pulse when rd_data is consumed (FIFO pop).
- busy  out  1  transaction active (synchronised CS low and armed).

Behaviour:
- Synchronisation: spics_n, spick and spido each pass through a 2-FF synchroniser; spick also gets an edge detector (rise/fall pulses).
  - Constraint: fclk ≥ 8 × spick frequency, and ≥ 4 fclk between spick edges.
- Reset values: spidi = IDLE_MISO; wr_stb = 0, rd_stb = 0, busy = 0; wr_addr = 0, wr_data = 0, rd_addr = 0; state = IDLE; bit counter = 0; armed = 0.
- armed:
  - Set when synchronised CS is seen high.
  - A transfer already in progress when rst is released is ignored until CS goes high.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE:
  - tx shift register continuously loads status.
  - Synchronised CS low with armed set → CMD, with bitcnt = 0.
- Bit handling in CMD, WDATA and RDATA:
  - spick rise: rx <= {rx[6:0], spido}; bitcnt++ (3-bit, wraps 7→0).
  - spick fall: if the byte just completed, load tx with the next byte; otherwise tx <= {tx[6:0], 0}.
  - spidi = tx[7] while busy, else IDLE_MISO.
- Byte complete, in CMD (8th rise):
  - Set addr = rx[6:0].
  - rx[7] = 1 → WDATA.
  - rx[7] = 0 → RDATA, and rd_addr = addr on the next fclk.
- Byte complete, in WDATA (8th rise):
  - wr_addr = addr, wr_data = rx, wr_stb = 1 for exactly one fclk.
  - Then addr++ if AUTOINC (7-bit, 7F→00).
- Byte complete, in RDATA (8th rise): no strobe.
- Next-byte load on spick fall after a complete byte:
  - RDATA: tx <= rd_data; rd_stb pulses for one fclk; then addr++ if AUTOINC and rd_addr follows addr.
  - WDATA: tx <= 8'h00.
- Read latency: the first read byte is the second SPI byte on the wire. Byte 1 returns status; byte 2 returns rd_data for address A.
- CS deassert (synchronised high) in any state:
  - → IDLE next fclk; bitcnt = 0.
  - A partial byte is discarded: no wr_stb, no rd_stb.
  - If deassert coincides with a completing 8th rise in the same fclk, CS wins and no strobe is issued.
- wr_stb and rd_stb are never both high in the same cycle.
- Extra spick edges while CS is high are ignored.
- rst asserted mid-transfer: immediate return to reset values and no strobe. Operation resumes only after CS high then low.

Decomposition:
- Shared package avr_spi_pkg:
  - state enum (IDLE/CMD/WDATA/RDATA);
  - CMD_WR_BIT = 7;
  - ADDR_W = 7, DATA_W = 8.
- Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall pulse generator. Instantiated for spick; spics_n and spido use its synchroniser-only path.

Test Plan:
- Write: CS low, send 0x85, 0x3C, CS high → one wr_stb with wr_addr = 0x05, wr_data = 0x3C; spidi byte 1 = status (0xA5 applied).
- Burst read, AUTOINC = 1: rd_data = f(addr) = addr ^ 0x55; send 0x10, 0x00, 0x00, 0x00 → MISO bytes status, 0x45, 0x44, 0x47; three rd_stb pulses; rd_addr ends at 0x13.
- Address wrap: write command 0xFF followed by 2 data bytes → wr_addr 0x7F then 0x00. With AUTOINC = 0 both writes go to 0x7F.
- Abort: command 0x81, 5 data bits, CS high → no wr_stb. The next full transaction decodes correctly from its first bit.
- Reset mid-transfer: assert rst during the 3rd bit of a data byte, release with CS still low, clock 16 more bits → no strobes, busy = 0, spidi = 1. After CS high→low, a normal write succeeds.
- Clock ratio margin: fclk = 8 × spick with random CS setup/hold → all bytes bit-exact and strobe count equals byte count.
